// File: rtl/multiplier_exec.sv
// multiplier_exec: registered state, step counter and radix-2 Booth shift-add datapath of a signed multiplier
//   clk          : single clock, rising edge
//   reset_n      : synchronous active-low reset
//   op_start     : start / step enable (shared with the next-state logic)
//   op_clear     : abort / clear (shared with the next-state logic)
//   multiplicand : signed operand A, captured at load
//   multiplier   : signed operand B, captured at load
//   next_state   : from the next-state logic (00 IDLE, 01 EXEC, 10 DONE)
//   state        : registered current state, fed back to the next-state logic
//   data_count   : registered Booth step count, fed back to the next-state logic
//   result       : signed 2*WIDTH-bit product
//   op_done      : high while state is DONE
module multiplier_exec #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               op_start,
   input  logic               op_clear,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic [1:0]         next_state,
   output logic [1:0]         state,
   output logic [CNT_W-1:0]   data_count,
   output logic [2*WIDTH-1:0] result,
   output logic               op_done
);
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] EXEC = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_count;
   logic [2*WIDTH-1:0] r_result;
   logic [WIDTH-1:0]   r_mcand;
   logic               r_booth;

   logic               w_clear;
   logic               w_load;
   logic               w_step;
   logic [WIDTH:0]     w_hi;
   logic [WIDTH:0]     w_mc;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_shifted;

   assign w_clear = op_clear && (next_state == IDLE);
   assign w_load  = (r_state == IDLE) && (next_state == EXEC);
   assign w_step  = (r_state == EXEC) && op_start && !op_clear && (r_count < CNT_W'(WIDTH));

   // One extra sign bit keeps the partial sum exact, e.g. 0 - (-2^31).
   assign w_hi = {r_result[2*WIDTH-1], r_result[2*WIDTH-1:WIDTH]};
   assign w_mc = {r_mcand[WIDTH-1], r_mcand};

   always_comb begin
      w_sum = ({r_result[0], r_booth} == 2'b01) ? w_hi + w_mc :
              ({r_result[0], r_booth} == 2'b10) ? w_hi - w_mc : w_hi;
   end

   // Arithmetic right shift of {sum, low half}: the extra sign bit becomes the new top bit.
   assign w_shifted = {w_sum, r_result[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_result <= '0;
         r_mcand  <= '0;
         r_booth  <= 1'b0;
      end else begin
         r_state <= next_state;
         if (w_clear) begin
            r_count  <= '0;
            r_result <= '0;
            r_booth  <= 1'b0;
         end else if (w_load) begin
            r_mcand  <= multiplicand;
            r_result <= {{WIDTH{1'b0}}, multiplier};
            r_booth  <= 1'b0;
            r_count  <= '0;
         end else if (w_step) begin
            r_result <= w_shifted;
            r_booth  <= r_result[0];
            r_count  <= r_count + CNT_W'(1);
         end
      end
   end

   assign state      = r_state;
   assign data_count = r_count;
   assign result     = r_result;
   assign op_done    = (r_state == DONE);
endmodule
